// File: rtl/pixel_streamer.sv
`default_nettype none
// pixel_streamer: reads a ROW_SIZE x COL_SIZE frame from 1-cycle-latency memory, emits a tagged ready/valid pixel stream.
// Revision 1.0

module pixel_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int ROW_SIZE   = 5,
  parameter int COL_SIZE   = 5,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                        clock,
  input  logic                        sreset_n,
  input  logic                        start,
  input  logic [ADDR_WIDTH-1:0]       base_addr,
  output logic                        mem_rd_en,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  input  logic [DATA_WIDTH-1:0]       mem_data,
  input  logic                        ready,
  output logic                        data_valid,
  output logic [DATA_WIDTH-1:0]       data_out,
  output logic [$clog2(COL_SIZE)-1:0] row_idx,
  output logic [$clog2(ROW_SIZE)-1:0] col_idx,
  output logic                        row_last,
  output logic                        frame_last,
  output logic                        busy,
  output logic                        done
);

  localparam int N     = ROW_SIZE * COL_SIZE;
  localparam int IDX_W = $clog2(N + 1);
  localparam int RW    = $clog2(COL_SIZE);
  localparam int CW    = $clog2(ROW_SIZE);
  localparam int EW    = DATA_WIDTH + RW + CW + 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] TOTAL    = IDX_W'(N);
  localparam logic [CW-1:0]    LAST_COL = CW'(ROW_SIZE - 1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE_S} state_t;

  state_t                 state, state_nxt;
  logic [ADDR_WIDTH-1:0]  base;
  logic [IDX_W-1:0]       rd_idx;
  logic [RW-1:0]          rd_row;
  logic [CW-1:0]          rd_col;
  logic                   inflight;
  logic [RW-1:0]          infl_row;
  logic [CW-1:0]          infl_col;
  logic                   infl_rl;
  logic                   infl_fl;
  logic [EW-1:0]          fifo_mem [2];
  logic [1:0]             count;
  logic                   wr_ptr;
  logic                   rd_ptr;
  logic                   push;
  logic                   pop;
  logic [EW-1:0]          head;

  assign push       = inflight;
  assign data_valid = (count != 2'd0);
  assign pop        = data_valid && ready;
  assign head       = fifo_mem[rd_ptr];
  assign busy       = (state != IDLE);
  assign done       = (state == DONE_S);
  assign mem_addr   = (state == STREAM) ? base + ADDR_WIDTH'(rd_idx) : '0;

  // Head fields are gated so the outputs read zero whenever the FIFO is empty.
  assign data_out   = data_valid ? head[EW-1 -: DATA_WIDTH] : '0;
  assign row_idx    = data_valid ? head[CW+2 +: RW] : '0;
  assign col_idx    = data_valid ? head[2 +: CW] : '0;
  assign row_last   = data_valid & head[1];
  assign frame_last = data_valid & head[0];

  always_comb begin
    state_nxt = state;
    mem_rd_en = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = STREAM;
      STREAM: begin
        mem_rd_en = (rd_idx < TOTAL) &&
                    (({1'b0, count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));
        if (mem_rd_en && (rd_idx == LAST_IDX)) state_nxt = DRAIN;
      end
      DRAIN:  if ((count == 2'd0) && !inflight) state_nxt = DONE_S;
      DONE_S: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge sreset_n) begin
    if (!sreset_n) state <= IDLE;
    else           state <= state_nxt;
  end

  always_ff @(posedge clock or negedge sreset_n) begin
    if (!sreset_n) begin
      base     <= '0;
      rd_idx   <= '0;
      rd_row   <= '0;
      rd_col   <= '0;
      inflight <= 1'b0;
      infl_row <= '0;
      infl_col <= '0;
      infl_rl  <= 1'b0;
      infl_fl  <= 1'b0;
    end else if ((state == IDLE) && start) begin
      base     <= base_addr;
      rd_idx   <= '0;
      rd_row   <= '0;
      rd_col   <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= mem_rd_en;
      if (mem_rd_en) begin
        infl_row <= rd_row;
        infl_col <= rd_col;
        infl_rl  <= (rd_col == LAST_COL);
        infl_fl  <= (rd_idx == LAST_IDX);
        rd_idx   <= rd_idx + 1'b1;
        if (rd_col == LAST_COL) begin
          rd_col <= '0;
          rd_row <= rd_row + 1'b1;
        end else begin
          rd_col <= rd_col + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge sreset_n) begin
    if (!sreset_n) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: contents are only visible while count is non-zero.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= {mem_data, infl_row, infl_col, infl_rl, infl_fl};
  end

  a_no_overflow: assert property (@(posedge clock) disable iff (!sreset_n)
                                  !(push && !pop && (count == 2'd2)));

endmodule

`default_nettype wire

// File: tb/tb_pixel_streamer.sv
`default_nettype none
// tb_pixel_streamer: directed checks of pixel_streamer (5x3 frame) plus a 2x2 address-wrap instance.
// Revision 1.0

module tb_pixel_streamer;

  logic        clock = 1'b0;
  logic        sreset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] base_addr = '0;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data = '0;
  logic        ready = 1'b1;
  logic        data_valid;
  logic [7:0]  data_out;
  logic [1:0]  row_idx;
  logic [2:0]  col_idx;
  logic        row_last, frame_last, busy, done;

  logic        start_b = 1'b0;
  logic [7:0]  base_b = 8'hFE;
  logic        mem_rd_en_b;
  logic [7:0]  mem_addr_b;
  logic [7:0]  mem_data_b = '0;
  logic        data_valid_b;
  logic [7:0]  data_out_b;
  logic [0:0]  row_idx_b, col_idx_b;
  logic        row_last_b, frame_last_b, busy_b, done_b;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int p_exp = 0;
  int rd_exp = 0;

  always #5 clock = ~clock;

  always @(posedge clock) if (mem_rd_en)   mem_data   <= mem_addr[7:0];
  always @(posedge clock) if (mem_rd_en_b) mem_data_b <= mem_addr_b;

  pixel_streamer #(.DATA_WIDTH(8), .ROW_SIZE(5), .COL_SIZE(3), .ADDR_WIDTH(16)) dut (
    .clock(clock), .sreset_n(sreset_n), .start(start), .base_addr(base_addr),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_data(mem_data), .ready(ready),
    .data_valid(data_valid), .data_out(data_out), .row_idx(row_idx), .col_idx(col_idx),
    .row_last(row_last), .frame_last(frame_last), .busy(busy), .done(done));

  pixel_streamer #(.DATA_WIDTH(8), .ROW_SIZE(2), .COL_SIZE(2), .ADDR_WIDTH(8)) dut_b (
    .clock(clock), .sreset_n(sreset_n), .start(start_b), .base_addr(base_b),
    .mem_rd_en(mem_rd_en_b), .mem_addr(mem_addr_b), .mem_data(mem_data_b), .ready(1'b1),
    .data_valid(data_valid_b), .data_out(data_out_b), .row_idx(row_idx_b), .col_idx(col_idx_b),
    .row_last(row_last_b), .frame_last(frame_last_b), .busy(busy_b), .done(done_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " rd_en"},      32'(mem_rd_en),  32'd0);
    chk({tag, " addr"},       32'(mem_addr),   32'd0);
    chk({tag, " valid"},      32'(data_valid), 32'd0);
    chk({tag, " data"},       32'(data_out),   32'd0);
    chk({tag, " row"},        32'(row_idx),    32'd0);
    chk({tag, " col"},        32'(col_idx),    32'd0);
    chk({tag, " row_last"},   32'(row_last),   32'd0);
    chk({tag, " frame_last"}, 32'(frame_last), 32'd0);
    chk({tag, " busy"},       32'(busy),       32'd0);
    chk({tag, " done"},       32'(done),       32'd0);
  endtask

  // start is sampled at the next edge (edge 0); afterwards we sit in cycle 1.
  task automatic begin_frame(input logic [15:0] b);
    start = 1'b1;
    base_addr = b;
    step();
    start = 1'b0;
    cyc = 1;
  endtask

  task automatic check_reads(input string tag);
    if (mem_rd_en) begin
      chk({tag, " addr"}, 32'(mem_addr), 32'(rd_exp));
      rd_exp++;
    end
  endtask

  task automatic check_pixel(input string tag);
    chk({tag, " data"},       32'(data_out),   32'(p_exp));
    chk({tag, " row"},        32'(row_idx),    32'(p_exp / 5));
    chk({tag, " col"},        32'(col_idx),    32'(p_exp % 5));
    chk({tag, " row_last"},   32'(row_last),   32'((p_exp % 5) == 4));
    chk({tag, " frame_last"}, 32'(frame_last), 32'(p_exp == 14));
  endtask

  // Runs the current frame to done, checking reads, pixel order, tags and stall stability.
  task automatic run_frame(input string tag, input bit rnd, input int inj);
    bit          held = 1'b0;
    bit          seen = 1'b0;
    logic [7:0]  h_data = '0;
    logic [1:0]  h_row = '0;
    logic [2:0]  h_col = '0;
    for (int i = 0; i < 200; i++) begin
      ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (cyc == inj) begin
        start = 1'b1;
        base_addr = 16'h0040;
      end else begin
        start = 1'b0;
      end
      #1;
      check_reads(tag);
      if (held) begin
        chk({tag, " stall data"}, 32'(data_out), 32'(h_data));
        chk({tag, " stall row"},  32'(row_idx),  32'(h_row));
        chk({tag, " stall col"},  32'(col_idx),  32'(h_col));
      end
      if (data_valid) check_pixel(tag);
      held   = data_valid && !ready;
      h_data = data_out;
      h_row  = row_idx;
      h_col  = col_idx;
      if (data_valid && ready) p_exp++;
      if (done) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    start = 1'b0;
    ready = 1'b1;
    chk({tag, " pixel count"}, 32'(p_exp), 32'd15);
    chk({tag, " read count"},  32'(rd_exp), 32'd15);
    chk({tag, " done seen"},   32'(seen), 32'd1);
    step();
  endtask

  int          nb;
  logic [7:0]  addrs_b [4];

  initial begin
    // Reset values
    repeat (2) @(posedge clock);
    #1;
    check_reset("reset");
    sreset_n = 1'b1;

    // Nominal frame, ready held high
    ready = 1'b1;
    begin_frame(16'h0000);
    for (int c = 1; c <= 21; c++) begin
      chk($sformatf("nom c%0d rd_en", c), 32'(mem_rd_en), 32'(c <= 15));
      if (c <= 15) chk($sformatf("nom c%0d addr", c), 32'(mem_addr), 32'(c - 1));
      chk($sformatf("nom c%0d valid", c), 32'(data_valid), 32'(c >= 3 && c <= 17));
      if (c >= 3 && c <= 17) begin
        p_exp = c - 3;
        check_pixel($sformatf("nom c%0d", c));
      end
      chk($sformatf("nom c%0d done", c), 32'(done), 32'(c == 19));
      chk($sformatf("nom c%0d busy", c), 32'(busy), 32'(c >= 1 && c <= 19));
      step();
    end

    // Random 50% backpressure
    p_exp = 0; rd_exp = 0;
    begin_frame(16'h0000);
    run_frame("rand", 1'b1, -1);

    // Ready low for the first 10 pixel cycles
    p_exp = 0; rd_exp = 0;
    ready = 1'b0;
    begin_frame(16'h0000);
    while (cyc <= 12) begin
      check_reads("stall");
      step();
    end
    chk("stall reads issued", 32'(rd_exp), 32'd2);
    chk("stall fifo full", 32'(data_valid), 32'd1);
    ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_reads("release");
      chk($sformatf("release p%0d valid", k), 32'(data_valid), 32'd1);
      check_pixel($sformatf("release p%0d", k));
      p_exp++;
      step();
    end
    run_frame("release tail", 1'b0, -1);

    // Address wrap on the 8-bit instance
    nb = 0;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mem_rd_en_b) begin
        if (nb < 4) addrs_b[nb] = mem_addr_b;
        nb++;
      end
      step();
    end
    chk("wrap read count", 32'(nb), 32'd4);
    chk("wrap addr0", 32'(addrs_b[0]), 32'h00FE);
    chk("wrap addr1", 32'(addrs_b[1]), 32'h00FF);
    chk("wrap addr2", 32'(addrs_b[2]), 32'h0000);
    chk("wrap addr3", 32'(addrs_b[3]), 32'h0001);

    // Mid-frame start with a different base is ignored
    p_exp = 0; rd_exp = 0;
    begin_frame(16'h0000);
    run_frame("midstart", 1'b0, 6);

    // Reset after pixel 6 transfers, then replay
    p_exp = 0; rd_exp = 0;
    begin_frame(16'h0000);
    while (cyc < 10) step();
    sreset_n = 1'b0;
    #1;
    check_reset("midreset");
    step();
    sreset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("postreset %0d rd_en", i), 32'(mem_rd_en), 32'd0);
      chk($sformatf("postreset %0d valid", i), 32'(data_valid), 32'd0);
      chk($sformatf("postreset %0d busy", i), 32'(busy), 32'd0);
      step();
    end
    p_exp = 0; rd_exp = 0;
    begin_frame(16'h0000);
    run_frame("replay", 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
